// File: rtl/ins_fetch_pkg.sv
// Shared widths, FSM state type and DDR request payload for the instruction fetcher.
package GLOBAL_PARAM;

  localparam int unsigned DDR_W      = 128;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned DDR_ADDR_W = 32;
  localparam int unsigned BURST_W    = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_DATA,
    S_DRAIN
  } ins_fetch_state_t;

  typedef struct packed {
    logic [DDR_ADDR_W-1:0] addr;
    logic [BURST_W-1:0]    size;
  } ddr_req_t;

endpackage

// File: rtl/ins_fetch_sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is visible the cycle after it is written.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       not_empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             not_empty_q, not_empty_d;

  always_comb begin
    wr_ptr_d    = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(wr_en) - CW'(rd_en);
    not_empty_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      not_empty_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      not_empty_q <= not_empty_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data   = not_empty_q ? mem_q[rd_ptr_q] : '0;
  assign not_empty = not_empty_q;
  assign count     = count_q;

endmodule

// File: rtl/ins_fetch.sv
// Fetches an instruction stream from DDR in bursts, unpacks each wide beat into
// INST_W slices and streams them out through a FIFO with credit-based request gating.
module ins_fetch
  import GLOBAL_PARAM::*;
#(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DDR_ADDR_W-1:0] start_addr,
  input  logic [15:0]           ins_num,
  output logic                  busy,
  output logic                  done,
  output logic [DDR_ADDR_W-1:0] ddr_addr,
  output logic [BURST_W-1:0]    ddr_size,
  output logic                  ddr_addr_valid,
  input  logic                  ddr_addr_ready,
  input  logic [DDR_W-1:0]      ddr_data,
  input  logic                  ddr_valid,
  output logic                  ddr_ready,
  output logic [INST_W-1:0]     ins,
  output logic                  ins_valid,
  input  logic                  ins_ready
);

  localparam int unsigned RATIO  = DDR_W / INST_W;
  localparam int unsigned LOG_R  = $clog2(RATIO);
  localparam int unsigned SL_W   = LOG_R + 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned NUM_W  = 16;
  localparam int unsigned NUM_W1 = NUM_W + 1;

  ins_fetch_state_t      state_q, state_d;
  logic [DDR_ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_W-1:0]      words_rem_q, words_rem_d;
  logic [NUM_W-1:0]      ins_left_q, ins_left_d;
  logic [SL_W-1:0]       tail_q, tail_d;
  logic [SL_W-1:0]       slices_left_q, slices_left_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic [BURST_W-1:0]    beats_left_q, beats_left_d;
  logic [DDR_W-1:0]      beat_q, beat_d;
  ddr_req_t              req_q, req_d;
  logic                  req_valid_q, req_valid_d;
  logic                  ddr_ready_q, ddr_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  fifo_wr_en;
  logic [INST_W-1:0]     fifo_wr_data;
  logic                  fifo_rd_en;
  logic [INST_W-1:0]     fifo_rd_data;
  logic                  fifo_not_empty;
  logic [CNT_W-1:0]      fifo_count;

  logic [BURST_W-1:0]    burst_c;
  logic [31:0]           need_c;
  logic [31:0]           free_c;
  logic [NUM_W1-1:0]     words_total_c;
  logic [SL_W-1:0]       nslices_c;

  sync_fifo #(
    .WIDTH (INST_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (fifo_wr_en),
    .wr_data   (fifo_wr_data),
    .rd_en     (fifo_rd_en),
    .rd_data   (fifo_rd_data),
    .not_empty (fifo_not_empty),
    .count     (fifo_count)
  );

  // Next-state, burst sizing, unpacking and output decode.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    words_rem_d   = words_rem_q;
    ins_left_d    = ins_left_q;
    tail_d        = tail_q;
    slices_left_d = slices_left_q;
    burst_d       = burst_q;
    beats_left_d  = beats_left_q;
    beat_d        = beat_q;
    req_d         = req_q;
    req_valid_d   = req_valid_q;
    done_d        = 1'b0;
    fifo_wr_en    = 1'b0;
    fifo_wr_data  = beat_q[INST_W-1:0];
    fifo_rd_en    = ins_ready && fifo_not_empty;

    burst_c       = (words_rem_q >= NUM_W'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                                                       : BURST_W'(words_rem_q);
    need_c        = 32'(burst_c) << LOG_R;
    free_c        = 32'(FIFO_DEPTH) - 32'(fifo_count);
    words_total_c = (NUM_W1'(ins_num) + NUM_W1'(RATIO - 1)) >> LOG_R;
    // The job's final word may carry fewer than RATIO useful slices.
    nslices_c     = (words_rem_q == NUM_W'(1) && tail_q != '0) ? tail_q : SL_W'(RATIO);

    if (fifo_rd_en && ins_left_q != '0) ins_left_d = ins_left_q - NUM_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ins_num == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = start_addr;
            words_rem_d = NUM_W'(words_total_c);
            tail_d      = SL_W'(ins_num & 16'(RATIO - 1));
            ins_left_d  = ins_num;
            state_d     = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (free_c >= need_c) begin
          burst_d      = burst_c;
          beats_left_d = burst_c;
          req_d.addr   = addr_q;
          req_d.size   = burst_c;
          req_valid_d  = 1'b1;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (ddr_addr_ready) begin
          req_valid_d = 1'b0;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (slices_left_q != '0) begin
          fifo_wr_en    = 1'b1;
          beat_d        = beat_q >> INST_W;
          slices_left_d = slices_left_q - SL_W'(1);
          if (slices_left_q == SL_W'(1) && beats_left_q == '0) begin
            addr_d  = addr_q + DDR_ADDR_W'(burst_q);
            state_d = (words_rem_q == '0) ? S_DRAIN : S_CHECK;
          end
        end else if (ddr_valid && ddr_ready_q) begin
          beat_d        = ddr_data;
          slices_left_d = nslices_c;
          beats_left_d  = beats_left_q - BURST_W'(1);
          words_rem_d   = words_rem_q - NUM_W'(1);
        end
      end
      S_DRAIN: begin
        if (ins_left_q == '0 || (ins_left_q == NUM_W'(1) && fifo_rd_en)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    // Beats are held off while the previous beat is still being unpacked.
    ddr_ready_d = (state_d == S_DATA) && (slices_left_d == '0) && (beats_left_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      words_rem_q   <= '0;
      ins_left_q    <= '0;
      tail_q        <= '0;
      slices_left_q <= '0;
      burst_q       <= '0;
      beats_left_q  <= '0;
      beat_q        <= '0;
      req_q         <= '0;
      req_valid_q   <= 1'b0;
      ddr_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      words_rem_q   <= words_rem_d;
      ins_left_q    <= ins_left_d;
      tail_q        <= tail_d;
      slices_left_q <= slices_left_d;
      burst_q       <= burst_d;
      beats_left_q  <= beats_left_d;
      beat_q        <= beat_d;
      req_q         <= req_d;
      req_valid_q   <= req_valid_d;
      ddr_ready_q   <= ddr_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign ddr_addr       = req_q.addr;
  assign ddr_size       = req_q.size;
  assign ddr_addr_valid = req_valid_q;
  assign ddr_ready      = ddr_ready_q;
  assign ins            = fifo_rd_data;
  assign ins_valid      = fifo_not_empty;

endmodule

// File: doc/ins_fetch.md
INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 Parameter FIFO_DEPTH, default 64, instruction FIFO depth in INST_W entries, power of two.
REQ-002 Parameter MAX_BURST, default 16, max DDR words per read request, power of two, <= 2^BURST_W - 1.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle pulse launching a fetch job; sampled only in IDLE.
REQ-006 start_addr  in  DDR_ADDR_W  first DDR word address of the instruction stream (DDR-word units).
REQ-007 ins_num  in  16  number of instructions in the job.
REQ-008 busy  out  1  high from accepted start until done.
REQ-009 done  out  1  one-cycle pulse when the last instruction is handshaken on ins.
REQ-010 ddr_addr / ddr_size / ddr_addr_valid  out  DDR_ADDR_W / BURST_W / 1  read request; size = DDR word count (1..MAX_BURST).
REQ-011 ddr_addr_ready  in  1  request accepted when valid&ready.
REQ-012 ddr_data / ddr_valid  in  DDR_W / 1  read data beats; ddr_ready  out  1.
REQ-013 ins / ins_valid  out  INST_W / 1; ins_ready  in  1  instruction stream to top_control.

Function
REQ-014 RATIO = DDR_W / INST_W, integer power of two; words_total = ceil(ins_num / RATIO).
REQ-015 FSM states IDLE, CHECK, REQ, DATA, DRAIN.
REQ-016 IDLE: start with ins_num>0 -> latch addr/count, busy=1, go CHECK; start with ins_num==0 -> done pulse next cycle, busy stays 0, no DDR traffic.
REQ-017 CHECK: burst = min(MAX_BURST, words_remaining); go REQ when FIFO free entries >= burst*RATIO, else hold.
REQ-018 REQ: ddr_addr_valid=1 with addr/size stable until ddr_addr_ready; then go DATA; only one request outstanding.
REQ-019 DATA: ddr_ready=1 only in DATA; each beat writes RATIO slices, lowest INST_W slice first, into FIFO (unpacker may serialise; beats held off via ddr_ready).
REQ-020 Final beat of job: only ins_num mod RATIO slices written when nonzero; remaining slices discarded.
REQ-021 After burst's last beat: addr += burst; words_remaining -= burst; go CHECK if words_remaining>0, else DRAIN.
REQ-022 DRAIN: wait until all ins_num instructions handshaken; done=1 that cycle; next state IDLE, busy=0.
REQ-023 ins_valid = FIFO not empty, independent of state; ins held stable while ins_valid & !ins_ready.
REQ-024 FIFO write and read in same cycle both succeed; full never overflows (guaranteed by REQ-017); read on empty impossible.
REQ-025 FIFO read latency: data written at cycle N visible on ins no later than N+1.
REQ-026 Address arithmetic wraps modulo 2^DDR_ADDR_W; no 4 KB boundary splitting.
REQ-027 Extra ddr_valid beats outside DATA ignored (ddr_ready=0).

Reset
REQ-028 rst low at any edge: FSM=IDLE, FIFO emptied, counters cleared; busy, done, ddr_addr_valid, ddr_ready, ins_valid = 0; ddr_addr, ddr_size, ins = 0.
REQ-029 Reset mid-job abandons the job with no done pulse; caller must drain any outstanding memory response externally.

Structure
REQ-030 DDR_W, INST_W, DDR_ADDR_W, BURST_W from GLOBAL_PARAM; FSM state typedef in GLOBAL_PARAM as ins_fetch_state_t.
REQ-031 One sub-module: sync_fifo (width INST_W, depth FIFO_DEPTH, count output for free-space check).

Verification (bench RATIO=4, MAX_BURST=16, FIFO_DEPTH=64)
REQ-032 start, addr=0x100, ins_num=8, ins_ready=1 -> one request addr 0x100 size 2; 8 instructions in memory order; done once; busy low after.
REQ-033 ins_num=70 -> requests (0x100,16) then (0x110,2); 70 instructions, slices 70..71 of last beat dropped; done after 70th handshake.
REQ-034 ins_ready=0 throughout, ins_num=100 -> 64 instructions buffered, second request withheld; raise ins_ready -> remaining requests issued, 100 total delivered.
REQ-035 ins_num=0 -> done pulse next cycle, ddr_addr_valid never asserted.
REQ-036 rst low during DATA of a 16-word burst -> all outputs zero next cycle, no done; fresh start ins_num=4 completes normally.
REQ-037 ddr_addr_ready delayed 5 cycles, random ddr_valid gaps -> addr/size stable while waiting, stream content unchanged.
